// File: rtl/alarma_pkg.sv
// alarma_pkg: shared state encoding, field widths and wrap helpers for the alarm clock
package alarma_pkg;
  localparam int HORA_W = 5;
  localparam int MIN_W = 6;
  localparam logic [HORA_W-1:0] MAX_HORA = 5'd23;
  localparam logic [MIN_W-1:0] MAX_MIN = 6'd59;
  typedef enum logic [2:0] {
    NORMAL    = 3'd0,
    SET_TIME  = 3'd1,
    SET_ALARM = 3'd2,
    RINGING   = 3'd3,
    SNOOZE    = 3'd4
  } estado_t;
  function automatic logic [HORA_W-1:0] inc_hora(input logic [HORA_W-1:0] h);
    return h == MAX_HORA ? '0 : h + 1'b1;
  endfunction
  function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] m);
    return m == MAX_MIN ? '0 : m + 1'b1;
  endfunction
endpackage

// File: rtl/divisor_tick.sv
// divisor_tick: prescaler giving a one-cycle second tick and a half-second strobe
module divisor_tick #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic reloj,
  input  logic reset,
  output logic seg_tick,
  output logic medio_tick
);
  localparam int W = $clog2(TICKS_PER_SEC);
  localparam logic [W-1:0] TOP = W'(TICKS_PER_SEC - 1);
  localparam logic [W-1:0] MID = W'(TICKS_PER_SEC / 2 - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge reloj)
    if (reset) cnt <= '0;
    else cnt <= seg_tick ? '0 : cnt + 1'b1;
  assign seg_tick = cnt == TOP;
  assign medio_tick = seg_tick || cnt == MID;
endmodule

// File: rtl/alarma_ctrl.sv
// alarma_ctrl: HH:MM:SS timebase, time/alarm setting and ring/snooze buzzer FSM.
// Define ZUMBADOR_PULSO_EN to make the buzzer toggle every half second while ringing.
module alarma_ctrl
  import alarma_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC = 60
) (
  input  logic              reloj,
  input  logic              reset,
  input  logic              alarma_on,
  input  logic              set_hora,
  input  logic              set_alarma,
  input  logic              btn_h,
  input  logic              btn_m,
  input  logic              btn_snooze,
  input  logic              btn_stop,
  output logic [HORA_W-1:0] hora,
  output logic [MIN_W-1:0]  minuto,
  output logic [MIN_W-1:0]  segundo,
  output logic [HORA_W-1:0] al_hora,
  output logic [MIN_W-1:0]  al_minuto,
  output logic              zumbador,
  output logic [2:0]        estado,
  output logic              seg_tick
);
  estado_t state, nxt;
  logic medio, adv, s_wrap, match_al, match_sn, ring_fin, sn_wrap;
  logic [HORA_W-1:0] t_hora, sn_hora, sn_hora_n;
  logic [MIN_W-1:0] t_min, t_seg, sn_min, sn_min_n;
  logic [MIN_W:0] sn_sum;
  logic [7:0] ring_cnt;

  divisor_tick #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_div (
    .reloj(reloj),
    .reset(reset),
    .seg_tick(seg_tick),
    .medio_tick(medio)
  );

  // Matches are taken against the time the tick is about to load, so the state
  // change lands on the same edge as the time update and fires only once.
  always_comb begin
    s_wrap = segundo == MAX_MIN;
    t_seg = s_wrap ? '0 : segundo + 1'b1;
    t_min = s_wrap ? inc_min(minuto) : minuto;
    t_hora = s_wrap && minuto == MAX_MIN ? inc_hora(hora) : hora;
    adv = seg_tick && state != SET_TIME;
    match_al = adv && s_wrap && alarma_on && t_hora == al_hora && t_min == al_minuto;
    match_sn = adv && s_wrap && t_hora == sn_hora && t_min == sn_min;
    ring_fin = seg_tick && ring_cnt == 8'(RING_SEC - 1);
    sn_sum = {1'b0, minuto} + 7'(SNOOZE_MIN);
    sn_wrap = sn_sum > {1'b0, MAX_MIN};
    sn_min_n = sn_wrap ? MIN_W'(sn_sum - 7'd60) : sn_sum[MIN_W-1:0];
    sn_hora_n = sn_wrap ? inc_hora(hora) : hora;
  end

  always_comb begin
    nxt = state;
    case (state)
      NORMAL:    nxt = set_hora ? SET_TIME : set_alarma ? SET_ALARM : match_al ? RINGING : NORMAL;
      SET_TIME:  nxt = set_hora ? SET_TIME : NORMAL;
      SET_ALARM: nxt = set_alarma ? SET_ALARM : NORMAL;
      RINGING:   nxt = btn_stop || !alarma_on || ring_fin ? NORMAL : btn_snooze ? SNOOZE : RINGING;
      SNOOZE:    nxt = btn_stop || !alarma_on ? NORMAL : match_sn ? RINGING : SNOOZE;
      default:   nxt = NORMAL;
    endcase
  end

  always_ff @(posedge reloj)
    if (reset) begin
      state <= NORMAL;
      ring_cnt <= '0;
      sn_hora <= '0;
      sn_min <= '0;
    end else begin
      state <= nxt;
      ring_cnt <= state != RINGING ? '0 : seg_tick ? ring_cnt + 1'b1 : ring_cnt;
      if (state == RINGING && btn_snooze) begin
        sn_hora <= sn_hora_n;
        sn_min <= sn_min_n;
      end
    end

  // SET_TIME never advances on a tick, so a coincident button simply wins.
  always_ff @(posedge reloj)
    if (reset) begin
      hora <= '0;
      minuto <= '0;
      segundo <= '0;
    end else if (adv) begin
      hora <= t_hora;
      minuto <= t_min;
      segundo <= t_seg;
    end else if (state == SET_TIME && (btn_h || btn_m)) begin
      hora <= btn_h ? inc_hora(hora) : hora;
      minuto <= btn_m ? inc_min(minuto) : minuto;
      segundo <= '0;
    end

  always_ff @(posedge reloj)
    if (reset) begin
      al_hora <= '0;
      al_minuto <= '0;
    end else if (state == SET_ALARM) begin
      al_hora <= btn_h ? inc_hora(al_hora) : al_hora;
      al_minuto <= btn_m ? inc_min(al_minuto) : al_minuto;
    end

  assign estado = state;

`ifdef ZUMBADOR_PULSO_EN
  logic zum_q;
  // Held at 1 outside RINGING so the first ringing half-second is audible.
  always_ff @(posedge reloj)
    if (reset) zum_q <= 1'b0;
    else zum_q <= state != RINGING ? 1'b1 : medio ? ~zum_q : zum_q;
  assign zumbador = state == RINGING && zum_q;
`else
  logic medio_unused;
  assign medio_unused = medio;
  assign zumbador = state == RINGING;
`endif
endmodule
